// File: rtl/result_drain_if.sv
// Result stream bus: one accumulator element per valid/ready handshake.
interface result_drain_if #(
    parameter int unsigned ACC_SIZE = 16,
    parameter int unsigned IDX_W    = 4
);
    logic [ACC_SIZE-1:0] out_data;
    logic [IDX_W-1:0]    out_index;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/result_drain.sv
// Captures the systolic array's result vector on a done rise and streams it
// out element by element, row-major, freeing the array for the next multiply.
module result_drain #(
    parameter int unsigned MAT_ROWS = 3,
    parameter int unsigned MAT_COLS = 3,
    parameter int unsigned MAT_LEN  = MAT_ROWS * MAT_COLS,
    parameter int unsigned ACC_SIZE = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MAT_LEN*ACC_SIZE-1:0] result_in,
    input  logic                        done_in,
    result_drain_if.master              drain,
    output logic                        busy,
    output logic                        overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_LEN - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACC_SIZE-1:0] shadow_q [MAT_LEN];
    logic [ACC_SIZE-1:0] shadow_d [MAT_LEN];
    logic [ACC_SIZE-1:0] elem [MAT_LEN];
    logic                overrun_q, overrun_d;
    logic                done_q;
    logic                rise;
    logic                handshake;
    logic                at_last;

    // Unpack the result bus; element 0 sits in the MSBs.
    for (genvar k = 0; k < int'(MAT_LEN); k++) begin : g_unpack
        assign elem[k] = result_in[(int'(MAT_LEN) - k) * int'(ACC_SIZE) - 1 -: ACC_SIZE];
    end

    assign rise      = done_in & ~done_q;
    assign handshake = (state_q == STREAM) & drain.out_ready;
    assign at_last   = (idx_q == LAST_IDX);

    // State, index, shadow and sticky overrun registers; done_q resets high so
    // the array's idle done level after reset is not mistaken for a completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b1;
            for (int k = 0; k < int'(MAT_LEN); k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            done_q    <= done_in;
            shadow_q  <= shadow_d;
        end
    end

    // Next state: capture on rise when free, advance on handshake, and flag a
    // rise that arrives while a drain still has elements beyond this cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    shadow_d = elem;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (handshake && at_last) begin
                    if (rise) begin
                        shadow_d = elem;
                        idx_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (rise) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered state or a mux of it.
    assign drain.out_valid = (state_q == STREAM);
    assign drain.out_index = idx_q;
    assign drain.out_data  = shadow_q[idx_q];
    assign drain.out_last  = at_last & (state_q == STREAM);
    assign busy            = (state_q == STREAM);
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_result_drain.sv
// Randomized + directed bench for result_drain with a queue-based reference
// model: each done rise either enqueues nine expected elements or marks an
// expected overrun; a negedge monitor compares the DUT against the queue.
`timescale 1ns/1ps
module tb_result_drain;

    localparam int LEN = 9;
    localparam int ACC = 16;
    localparam int IW  = 4;
    localparam int RW  = LEN * ACC;

    logic          clk = 1'b0;
    logic          reset;
    logic          done_in;
    logic [RW-1:0] result_in;
    logic          busy;
    logic          overrun;

    result_drain_if #(.ACC_SIZE(ACC), .IDX_W(IW)) drain_if ();

    result_drain dut (
        .clk       (clk),
        .reset     (reset),
        .result_in (result_in),
        .done_in   (done_in),
        .drain     (drain_if),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC-1:0] data;
        int             idx;
    } exp_t;

    exp_t sbq[$];
    int   rem;
    logic ovr_exp;
    logic done_prev;
    bit   rst_seen;
    bit   mon_en;
    int   checks;
    int   errors;

    function automatic logic [RW-1:0] pack(input int base);
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < LEN; k++) begin
            r = (r << ACC) | RW'(ACC'(base + k));
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_pack();
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < LEN; k++) begin
            r = (r << ACC) | RW'(ACC'($urandom));
        end
        return r;
    endfunction

    function automatic logic [ACC-1:0] elem_of(input logic [RW-1:0] r, input int k);
        return ACC'(r >> ((LEN - 1 - k) * ACC));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model for the edge just passed, using the inputs present at it.
    function automatic void model_step();
        bit hs;
        bit rise;
        if (!reset) begin
            sbq.delete();
            rem       = 0;
            ovr_exp   = 1'b0;
            done_prev = 1'b1;
            rst_seen  = 1'b1;
            return;
        end
        hs        = (rem > 0) && (drain_if.out_ready === 1'b1);
        rise      = done_in && !done_prev;
        done_prev = done_in;
        if (hs) rem--;
        if (rise) begin
            if (rem == 0) begin
                for (int k = 0; k < LEN; k++) begin
                    exp_t e;
                    e.data = elem_of(result_in, k);
                    e.idx  = k;
                    sbq.push_back(e);
                end
                rem = LEN;
            end else begin
                ovr_exp = 1'b1;
            end
        end
    endfunction

    task automatic drive(input logic rst, input logic d, input logic [RW-1:0] r, input logic rdy);
        @(posedge clk);
        #1;
        model_step();
        reset              = rst;
        done_in            = d;
        result_in          = r;
        drain_if.out_ready = rdy;
    endtask

    // Monitor: compare outputs mid-cycle against the scoreboard head.
    always @(negedge clk) begin
        bit ev;
        if (mon_en) begin
            ev = (sbq.size() > 0);
            check("out_valid", 32'(drain_if.out_valid), 32'(ev));
            check("busy", 32'(busy), 32'(ev));
            check("overrun", 32'(overrun), 32'(ovr_exp));
            if (rst_seen) begin
                check("rst_out_data", 32'(drain_if.out_data), 32'd0);
                check("rst_out_index", 32'(drain_if.out_index), 32'd0);
                check("rst_out_last", 32'(drain_if.out_last), 32'd0);
                rst_seen = 1'b0;
            end
            if (ev) begin
                check("out_data", 32'(drain_if.out_data), 32'(sbq[0].data));
                check("out_index", 32'(drain_if.out_index), 32'(sbq[0].idx));
                check("out_last", 32'(drain_if.out_last), 32'(sbq[0].idx == LEN - 1));
                if (drain_if.out_ready === 1'b1) void'(sbq.pop_front());
            end else begin
                check("out_last_idle", 32'(drain_if.out_last), 32'd0);
            end
        end
    end

    initial begin
        logic [RW-1:0] d1;
        logic [RW-1:0] d100;
        logic          dr;
        logic [RW-1:0] rr;
        reset              = 1'b0;
        done_in            = 1'b1;
        result_in          = '0;
        drain_if.out_ready = 1'b0;
        checks    = 0;
        errors    = 0;
        rem       = 0;
        ovr_exp   = 1'b0;
        done_prev = 1'b1;
        rst_seen  = 1'b0;
        mon_en    = 1'b0;
        d1        = pack(1);
        d100      = pack(100);

        drive(1'b0, 1'b1, '0, 1'b0);
        mon_en = 1'b1;
        drive(1'b1, 1'b1, '0, 1'b0);

        // Basic drain
        repeat (3) drive(1'b1, 1'b0, d1, 1'b1);
        repeat (13) drive(1'b1, 1'b1, d1, 1'b1);

        // Back-pressure, result_in changed mid-drain
        drive(1'b1, 1'b0, d1, 1'b1);
        drive(1'b1, 1'b1, d1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b1, (i >= 5) ? pack(500) : d1, (i % 3) == 0);
        end

        // Overrun: second rise during element 4
        drive(1'b1, 1'b0, d1, 1'b1);
        drive(1'b1, 1'b1, d1, 1'b1);
        repeat (3) drive(1'b1, 1'b1, d1, 1'b1);
        drive(1'b1, 1'b0, d100, 1'b1);
        drive(1'b1, 1'b1, d100, 1'b1);
        repeat (10) drive(1'b1, 1'b1, d100, 1'b1);

        // Back-to-back: rise coincides with final handshake
        drive(1'b0, 1'b1, d1, 1'b1);
        drive(1'b1, 1'b1, d1, 1'b1);
        drive(1'b1, 1'b0, d1, 1'b1);
        drive(1'b1, 1'b1, d1, 1'b1);
        repeat (7) drive(1'b1, 1'b1, d1, 1'b1);
        drive(1'b1, 1'b0, d100, 1'b1);
        drive(1'b1, 1'b1, d100, 1'b1);
        repeat (12) drive(1'b1, 1'b1, d100, 1'b1);

        // Reset mid-stream, release with done held high, then a fresh rise
        drive(1'b1, 1'b0, d1, 1'b1);
        drive(1'b1, 1'b1, d1, 1'b1);
        repeat (4) drive(1'b1, 1'b1, d1, 1'b1);
        drive(1'b0, 1'b1, d1, 1'b1);
        repeat (5) drive(1'b1, 1'b1, d1, 1'b1);
        drive(1'b1, 1'b0, pack(200), 1'b1);
        drive(1'b1, 1'b1, pack(200), 1'b1);
        repeat (12) drive(1'b1, 1'b1, pack(200), 1'b1);

        // Post-reset idle with done held high
        drive(1'b0, 1'b1, d1, 1'b1);
        repeat (20) drive(1'b1, 1'b1, rand_pack(), 1'($urandom_range(0, 1)));

        // Random traffic
        dr = 1'b1;
        rr = rand_pack();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) dr = ~dr;
            if ($urandom_range(0, 2) == 0) rr = rand_pack();
            drive(1'($urandom_range(0, 299) != 0), dr, rr, 1'($urandom_range(0, 9) < 7));
        end
        repeat (15) drive(1'b1, 1'b1, rr, 1'b1);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
